dm_responder: RTL and testbench

//   Data-memory responder: the memory side of the CPU top's m_data_* interface.

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dm_responder_if.sv | 33 +++
 rtl/dm_trace_fifo.sv | 65 ++++++
 rtl/dm_responder.sv | 88 ++++++++
 tb/tb_dm_responder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: trace entry layout,
// memory map constants and the byte-lane merge used on stores.
package dm_pkg;

  localparam logic [31:0] DM_BASE  = 32'h0;
  localparam int          DM_WORDS = 3072;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  // Lanes with byteen set take the new byte; the rest keep the old word.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [3:0]  byteen
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU-side data port plus trace drain port of the data-memory responder.
interface dm_responder_if #(
  parameter int TRACE_DEPTH = 4
);
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic [31:0]   m_data_addr;
  logic [31:0]   m_data_wdata;
  logic [3:0]    m_data_byteen;
  logic [31:0]   m_inst_addr;
  logic [31:0]   m_data_rdata;
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_pc;
  logic [31:0]   trace_addr;
  logic [31:0]   trace_data;
  logic [CW-1:0] trace_count;
  logic          overflow;
  logic          addr_err;

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, overflow, addr_err
  );

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, overflow, addr_err
  );

endinterface

// File: rtl/dm_trace_fifo.sv
// Store-trace FIFO: no empty bypass, pop-then-push when full, sticky overflow
// when a push finds the FIFO full with no simultaneous pop.
module dm_trace_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  trace_entry_t i_entry,
  input  logic         i_pop,
  output trace_entry_t o_head,
  output logic         o_valid,
  output logic [CW-1:0] o_count,
  output logic         o_overflow
);

  trace_entry_t  r_store [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_store[r_wr_ptr] <= i_entry;
  end

  assign o_head     = w_empty ? '0 : r_store[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zero-latency word reads, byte-enabled writes on the
// edge, and a trace of every committed store drained over valid/ready.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WORDS  = DM_WORDS,
  parameter int TRACE_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam int AW = $clog2(ADDR_WORDS);
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic [31:0]           r_mem [ADDR_WORDS];
  logic [ADDR_WORDS-1:0] r_word_valid;
  logic                  r_addr_err;

  logic [29:0]   w_idx;
  logic [AW-1:0] w_widx;
  logic          w_in_range;
  logic          w_any_be;
  logic          w_hit;
  logic          w_write;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  trace_entry_t  w_entry;
  trace_entry_t  w_head;
  logic          w_valid;
  logic [CW-1:0] w_count;
  logic          w_overflow;
  logic          w_unused;

  assign w_idx      = bus.m_data_addr[31:2];
  assign w_widx     = w_idx[AW-1:0];
  assign w_in_range = (w_idx < 30'(ADDR_WORDS));
  assign w_any_be   = (bus.m_data_byteen != 4'b0000);
  assign w_unused   = ^bus.m_data_addr[1:0];

  // Never-written words read as zero, so reset only needs to clear the bitmap.
  assign w_hit    = w_in_range && r_word_valid[w_widx];
  assign w_old    = w_hit ? r_mem[w_widx] : 32'h0;
  assign w_write  = w_any_be && w_in_range;
  assign w_merged = merge_bytes(w_old, bus.m_data_wdata, bus.m_data_byteen);

  assign bus.m_data_rdata = w_old;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_valid <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      if (w_write) r_word_valid[w_widx] <= 1'b1;
      if (w_any_be && !w_in_range) r_addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[w_widx] <= w_merged;
  end

  assign w_entry = '{pc: bus.m_inst_addr, addr: {w_idx, 2'b00}, data: w_merged};

  dm_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (w_write),
    .i_entry    (w_entry),
    .i_pop      (bus.trace_ready),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_count    (w_count),
    .o_overflow (w_overflow)
  );

  assign bus.trace_valid = w_valid;
  assign bus.trace_pc    = w_head.pc;
  assign bus.trace_addr  = w_head.addr;
  assign bus.trace_data  = w_head.data;
  assign bus.trace_count = w_count;
  assign bus.overflow    = w_overflow;
  assign bus.addr_err    = r_addr_err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: bench-side memory model plus a queue of
// expected trace entries, compared against the DUT every cycle.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int DEPTH = 4;
  localparam int WORDS = 3072;

  logic clk;
  logic reset;

  dm_responder_if #(.TRACE_DEPTH(DEPTH)) bus();

  dm_responder #(
    .ADDR_WORDS  (WORDS),
    .TRACE_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0]  m_mem [int unsigned];
  trace_entry_t q[$];
  logic         exp_ovf;
  logic         exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned i;
    i = {2'b00, a[31:2]};
    if (i < WORDS && m_mem.exists(i)) return m_mem[i];
    return 32'h0;
  endfunction

  task automatic check_state(input string step);
    trace_entry_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk({step, ":count"},    32'(bus.trace_count), 32'(q.size()));
    chk({step, ":valid"},    32'(bus.trace_valid), 32'(q.size() != 0));
    chk({step, ":overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({step, ":addr_err"}, 32'(bus.addr_err), 32'(exp_err));
    chk({step, ":trace_pc"},   bus.trace_pc,   h.pc);
    chk({step, ":trace_addr"}, bus.trace_addr, h.addr);
    chk({step, ":trace_data"}, bus.trace_data, h.data);
  endtask

  // One clock: drive at negedge, check the pre-edge read, update the model,
  // then check the post-edge state at the following negedge.
  task automatic cycle(input string step, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] pc, input logic rdy);
    int unsigned  idx;
    logic [31:0]  merged;
    trace_entry_t e;
    bus.m_data_addr   = a;
    bus.m_data_wdata  = wd;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = rdy;
    #1;
    chk({step, ":rdata"}, bus.m_data_rdata, model_read(a));
    idx = {2'b00, a[31:2]};
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (be != 4'b0000) begin
      if (idx < WORDS) begin
        merged = model_read(a);
        for (int k = 0; k < 4; k++)
          if (be[k]) merged[8*k +: 8] = wd[8*k +: 8];
        m_mem[idx] = merged;
        e.pc   = pc;
        e.addr = {a[31:2], 2'b00};
        e.data = merged;
        if (q.size() < DEPTH) q.push_back(e);
        else exp_ovf = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    $display("step %s addr=%08h be=%b rdy=%0d -> count=%0d valid=%0d", step, a, be, rdy,
             bus.trace_count, bus.trace_valid);
    check_state(step);
  endtask

  initial begin
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    reset = 1'b1;
    bus.m_data_addr   = 32'h10;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'b0000;
    bus.m_inst_addr   = 32'h0;
    bus.trace_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset:rdata", bus.m_data_rdata, 32'h0);
    check_state("reset");

    // Full-word store, visible only after the edge
    cycle("sw",      32'h20, 32'h12345678, 4'b1111, 32'h3004, 1'b0);
    cycle("sw_rd",   32'h20, 32'h0,        4'b0000, 32'h0,    1'b0);
    cycle("drain1",  32'h20, 32'h0,        4'b0000, 32'h0,    1'b1);

    // Single-byte store into the same word
    cycle("sb",      32'h22, 32'h00AB0000, 4'b0100, 32'h3008, 1'b0);
    cycle("sb_rd",   32'h20, 32'h0,        4'b0000, 32'h0,    1'b0);
    cycle("drain2",  32'h20, 32'h0,        4'b0000, 32'h0,    1'b1);

    // Fill past capacity with the consumer stalled
    for (int k = 0; k < 5; k++)
      cycle("fill", 32'h40 + 32'(4*k), 32'hA0000000 + 32'(k), 4'b1111,
            32'h3100 + 32'(4*k), 1'b0);
    cycle("full_pp", 32'h60, 32'hCAFEF00D, 4'b0011, 32'h3200, 1'b1);
    for (int k = 0; k < 4; k++)
      cycle("drain3", 32'h44 + 32'(4*k), 32'h0, 4'b0000, 32'h0, 1'b1);

    // Range boundaries: last valid word, then first invalid one
    cycle("last_wd", 32'h2FFC, 32'h5A5AA5A5, 4'b1001, 32'h3300, 1'b0);
    cycle("oob_wr",  32'h3000, 32'hDEADBEEF, 4'b1111, 32'h3304, 1'b0);
    cycle("oob_rd",  32'h3000, 32'h0,        4'b0000, 32'h0,    1'b0);
    cycle("drain4",  32'h2FFC, 32'h0,        4'b0000, 32'h0,    1'b1);

    // Empty with push+pop: pop ignored, push accepted
    cycle("emp_pp",  32'h24, 32'h11111111, 4'b1111, 32'h3400, 1'b1);
    cycle("q2",      32'h28, 32'h22222222, 4'b1111, 32'h3404, 1'b0);
    cycle("q3",      32'h2C, 32'h33333333, 4'b1111, 32'h3408, 1'b0);

    // Async reset mid-drain with three entries queued
    bus.m_data_addr   = 32'h20;
    bus.m_data_byteen = 4'b0000;
    bus.trace_ready   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    m_mem.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    chk("async_rst:rdata", bus.m_data_rdata, 32'h0);
    check_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst", 32'h20, 32'h0, 4'b0000, 32'h0, 1'b0);
    cycle("post_wr",  32'h30, 32'h0000BEEF, 4'b0011, 32'h3500, 1'b0);
    cycle("post_rd",  32'h30, 32'h0,        4'b0000, 32'h0,    1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
